// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NREQ valid/ready
// message streams, with a per-grant burst limit and an idle gap between grants.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int GAP       = 2
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    input  logic [NREQ-1:0]    req_last_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               tx_valid_o,
    output logic [DW-1:0]      tx_data_o,
    input  logic               tx_ready_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o
);
    localparam int         IW        = $clog2(NREQ);
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [3:0] GAP_INIT  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] sel_idx;
    logic [7:0]    burst_cnt;
    logic [7:0]    burst_nxt;
    logic [3:0]    gap_cnt;
    logic [DW-1:0] data_sel;
    logic          found;
    logic          accept;
    logic          release_now;
    int unsigned   idx;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid_i[IW'(idx)]) begin
                found   = 1'b1;
                sel_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                data_sel = req_data_i[k*DW +: DW];
            end
        end
        tx_valid_o           = busy_o & req_valid_i[gnt_idx];
        tx_data_o            = busy_o ? data_sel : '0;
        accept               = tx_valid_o & tx_ready_i;
        req_ready_o          = '0;
        req_ready_o[gnt_idx] = accept;
        burst_nxt            = burst_cnt + 8'd1;
        release_now          = accept & (req_last_i[gnt_idx] | (burst_nxt == BURST_LIM));
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            grant_o   <= '0;
            busy_o    <= 1'b0;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state     <= ST_XFER;
                        gnt_idx   <= sel_idx;
                        grant_o   <= NREQ'(1) << sel_idx;
                        busy_o    <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (accept) begin
                        burst_cnt <= burst_nxt;
                    end
                    if (release_now) begin
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        rr_ptr  <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_INIT;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter among NREQ requesters. Each requester offers a message as a valid/ready byte stream with a last flag. The arbiter grants one requester at a time and holds the grant for the whole message, up to a burst limit. It forwards bytes to the transmitter's valid/ready byte port and inserts a configurable idle gap between grants.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 8: data width per byte
- MAX_BURST, 16: maximum bytes per grant, 1..255
- GAP, 2: idle cycles between a release and the next arbitration, 0..15

- sysclk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_i  in  NREQ  requester i has a byte available
- req_data_i  in  NREQ*DW  byte of requester i in bits [i*DW +: DW]
- req_last_i  in  NREQ  byte of requester i is the final byte of its message
- req_ready_o  out  NREQ  byte of requester i accepted this cycle (valid & ready)
- tx_valid_o  out  1  byte presented to transmitter
- tx_data_o  out  DW  byte to transmitter
- tx_ready_i  in  1  transmitter can accept a byte this cycle
- grant_o  out  NREQ  one-hot current owner, registered
- busy_o  out  1  a grant is active

## Operation
- States: IDLE, XFER, GAP.
- Reset state, asynchronous: IDLE; grant_o=0, busy_o=0, tx_valid_o=0, tx_data_o=0, req_ready_o=0, rr_ptr=0, burst_cnt=0, gap_cnt=0.
- IDLE:
  - If any req_valid_i is high, select the first set bit searching from rr_ptr upward, modulo NREQ.
  - Register grant_o to that one-hot value, set busy_o=1, clear burst_cnt, go to XFER.
  - No valid requests: stay in IDLE.
- XFER, granted index g:
  - tx_valid_o = req_valid_i[g], combinational.
  - tx_data_o = req_data_i[g] while busy_o is high; otherwise 0.
  - req_ready_o[g] = tx_ready_i & req_valid_i[g]; all other bits 0.
  - Accept = tx_valid_o & tx_ready_i; on each accept, burst_cnt increments.
  - Release when an accepted byte has req_last_i[g]=1, or when burst_cnt reaches MAX_BURST (that byte is the MAX_BURST-th).
  - On release: grant_o=0, busy_o=0, rr_ptr=(g+1) mod NREQ.
  - Next state is GAP with gap_cnt=GAP-1, or IDLE directly if GAP=0.
  - If the granted requester drops valid mid-message, hold the grant indefinitely. Nothing is forwarded and no other requester is served.
- GAP: outputs are idle as in reset; gap_cnt decrements; go to IDLE when gap_cnt reaches 0. Requests arriving here are held until IDLE.
- A requester truncated by MAX_BURST keeps its remaining bytes. It rejoins arbitration with rr_ptr already past it.
- req_last_i is ignored on non-granted requesters and on non-accepted cycles.
- burst_cnt width: 8 bits; compare against MAX_BURST with an equality check after the increment.
- tx_valid_o may rise and fall while granted. The arbiter never retracts a byte itself; stability is the requester's job.

## Timing
- Request to grant: req_valid_i sampled high in IDLE at edge k gives grant_o/busy_o high after edge k. The first byte can be accepted in cycle k+1.
- Throughput while granted: 1 byte per cycle when valid and ready are both high. Zero added latency on data, which is a combinational mux.
- Release: grant_o is low in the cycle after the final accept.
- Release to next grant: GAP+1 edges minimum, since IDLE costs one arbitration edge.
- Ready/valid are combinational in XFER and 0 in every other state.
- An asynchronous reset mid-message discards the grant and counters immediately. Outputs go to their reset values without waiting for a clock.

## Test plan
- Single requester: req 1 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready_i=1 -> grant_o=0010, tx_data_o sequence 41,42,43 on consecutive cycles. grant_o=0 next cycle, then 2 GAP cycles, then IDLE.
- Round robin: all 4 requesters request with 1-byte messages from reset -> grant order 0,1,2,3,0. Each grant is separated by 3 edges (GAP=2 plus arbitration).
- Burst limit: MAX_BURST=16, req 2 streams 20 bytes with no last -> release after the 16th accept. Reqs 3,0,1 are served if requesting; req 2 resumes with byte 17 on its next grant.
- Backpressure: tx_ready_i toggles 1,0,0,1 during a 2-byte message -> each byte is accepted exactly once. req_ready_o is asserted only on cycles where tx_ready_i=1, and no byte is duplicated or dropped.
- Stall: the granted requester drops valid for 10 cycles mid-message while others request -> grant_o is unchanged and tx_valid_o=0 for those cycles. The message then completes and other requesters are not served before the release.
- Reset mid-message: reset_n is low asynchronously during byte 2 of 4 -> grant_o, busy_o, tx_valid_o and req_ready_o are 0 immediately. After release of reset, req 0 has priority again.
